// File: rtl/case2_bist.sv
// Built-in self-test sequencer for the case2 netlist: drives all 32 input vectors,
// checks responses against a golden model, and compresses them into a 16-bit MISR.
module case2_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  input  logic        x_i,
  input  logic        y_i,
  input  logic        z_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic        fail_valid,
  output logic [4:0]  fail_vec,
  output logic [15:0] signature,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [4:0]  vec_q, vec_d;
  logic [3:0]  wait_q, wait_d;
  logic [4:0]  stim_q, stim_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [5:0]  err_q, err_d;
  logic        fv_q, fv_d;
  logic [4:0]  fvec_q, fvec_d;
  logic [15:0] sig_q, sig_d;

  logic        x_exp, yz_exp, mismatch;
  logic [5:0]  err_inc;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    sig_d   = sig_q;

    x_exp    = stim_q[4] & stim_q[3] & (stim_q[2] | stim_q[1]) & ~stim_q[0];
    yz_exp   = ~(&stim_q);
    mismatch = ({x_i, y_i, z_i} != {x_exp, yz_exp, yz_exp});
    err_inc  = (err_q == 6'd63) ? err_q : err_q + 6'd1;

    // start is a level request taken only in IDLE/DONE (busy=0 means ready);
    // abort overrides start and, while busy, cancels the run on the next edge.
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          vec_d   = 5'd0;
          err_d   = 6'd0;
          fv_d    = 1'b0;
          fvec_d  = 5'd0;
          sig_d   = 16'hFFFF;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        stim_d  = vec_q;
        wait_d  = 4'd0;
        state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_SAMPLE;
        else                     wait_d  = wait_q + 4'd1;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = err_inc;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
        end
        sig_d = ({sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000))
                ^ {13'b0, x_i, y_i, z_i};
        if (vec_q == 5'd31) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 6'd0);
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 5'd1;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort keeps the diagnostic results of the partial run visible.
    if (abort && (state_q == S_APPLY || state_q == S_WAIT || state_q == S_SAMPLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      vec_d   = vec_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fvec_d  = fvec_q;
      sig_d   = sig_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 5'd0;
      wait_q  <= 4'd0;
      stim_q  <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 6'd0;
      fv_q    <= 1'b0;
      fvec_q  <= 5'd0;
      sig_q   <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      sig_q   <= sig_d;
    end
  end

  assign {a, b, c, d, e} = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
  assign signature  = sig_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/case2_bist.md
CASE2_BIST -- requirements
Module: case2_bist

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, range 0..15, giving the number of wait cycles between applying a vector and sampling the response.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: cancels a run in progress.
REQ-006 The block SHALL have ports a, b, c, d, e, outputs, 1 bit each: registered stimulus to the case2 netlist under test.
REQ-007 The block SHALL have ports x_i, y_i, z_i, inputs, 1 bit each: responses returned from the netlist under test.
REQ-008 The block SHALL have port busy, output, 1 bit: high from run start until the run completes or is aborted.
REQ-009 The block SHALL have port done, output, 1 bit: high after a completed run, held until the next accepted start.
REQ-010 The block SHALL have port pass, output, 1 bit: valid with done; 1 when err_count is 0.
REQ-011 The block SHALL have port err_count, output, 6 bits: number of failing vectors.
REQ-012 The block SHALL have port fail_valid, output, 1 bit: at least one failure has been captured.
REQ-013 The block SHALL have port fail_vec, output, 5 bits: the first failing vector {a,b,c,d,e}.
REQ-014 The block SHALL have port signature, output, 16 bits: the MISR over all sampled responses.

Function
REQ-015 The FSM SHALL have states IDLE, APPLY, WAIT, SAMPLE and DONE; DONE behaves as IDLE for start acceptance.
REQ-016 In IDLE or DONE with start=1, the block SHALL do all of the following and go to APPLY:
- clear the vector counter vec[4:0], err_count, fail_valid and fail_vec;
- seed signature to 16'hFFFF;
- clear done and set busy.
REQ-017 In APPLY, the block SHALL register {a,b,c,d,e} <= vec, with a as the MSB, and go to WAIT, or go straight to SAMPLE when SETTLE=0.
REQ-018 WAIT SHALL last exactly SETTLE cycles, then go to SAMPLE.
REQ-019 The golden model SHALL be: x_exp = a&b&(c|d)&~e; y_exp = z_exp = ~(a&b&c&d&e), evaluated on the registered stimulus.
REQ-020 In SAMPLE, a vector SHALL fail when {x_i,y_i,z_i} differs from {x_exp,y_exp,z_exp} in any bit.
- On failure, err_count SHALL increment.
- The first failure SHALL set fail_valid=1 and capture fail_vec=vec; later failures SHALL NOT overwrite it.
REQ-021 In SAMPLE, signature SHALL update as signature <= ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)) ^ {13'b0,x_i,y_i,z_i}.
REQ-022 After SAMPLE with vec=31, the block SHALL set busy=0 and done=1, set pass=(err_count_final==0), and go to DONE; otherwise it SHALL increment vec and go to APPLY.
REQ-023 Vectors SHALL be applied in ascending order 0..31 with no wrap-around and no repeats; each vector SHALL take 2+SETTLE cycles, so a run takes 32*(2+SETTLE) cycles (96 at the default) from the accepting edge to busy falling.
REQ-024 The block SHALL ignore start while busy=1.
REQ-025 When abort=1 in any busy state, the block SHALL go to IDLE on the next edge with busy=0 and done=0, and SHALL leave err_count, fail_valid, fail_vec and signature holding their last values; abort and start together in IDLE SHALL have abort win (no run).
REQ-026 err_count SHALL saturate at 63; it cannot exceed 32 in a legal run.
REQ-027 pass SHALL read 0 whenever done=0.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously hold:
- state IDLE and vec=0;
- a..e=0;
- busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0;
- signature=16'hFFFF.
REQ-029 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.

Verification
REQ-030 Reference model case2 connected, SETTLE=1, start pulsed -> busy high for exactly 96 cycles, then done=1, pass=1, err_count=0, fail_valid=0, and signature equal to the bench model of REQ-021.
REQ-031 x_i stuck at 0 -> err_count=3, fail_vec=5'd26, pass=0.
REQ-032 y_i stuck at 1 -> err_count=1, fail_vec=5'd31; z_i stuck at 0 -> err_count=31, fail_vec=5'd0.
REQ-033 SETTLE=0 and SETTLE=15 runs -> busy lasts 64 and 544 cycles respectively; a start pulse mid-run has no effect.
REQ-034 abort at cycle 40 of a run -> busy=0 and done=0 next cycle; a following start restarts from vec=0 with counters cleared.
REQ-035 rst_n low at cycle 50 of a run -> all outputs take their reset values immediately (before the next clock edge); a start after release gives a full, correct run.
